// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received-word holding register handshake between UART receiver and register block
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_parity_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with parity, break detect and holding register
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RxD,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  uart_rx_param_if.master  rx,
  output logic             rx_break,
  output logic             rx_overrun,
  output logic             rx_done,
  output logic             rx_busy
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] S_LO   = SW'(M - 1);
  localparam logic [SW-1:0] S_MID  = SW'(M);
  localparam logic [SW-1:0] S_DEC  = SW'(M + 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } state_t;

  state_t state, state_nx;

  logic                 rx_meta, rxs;
  logic [DIV_W-1:0]     tick_cnt, div_l, div_src, div_eff;
  logic                 tick;
  logic [SW-1:0]        s_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 samp0, samp1;
  logic                 maj, dec, eob;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, par_err, fe_acc, stop0_zero;
  logic                 par_en_l, par_odd_l, stop2_l;
  logic                 start_det, last_stop, first_stop_zero, brk_now, fe_now;
  logic                 frame_end;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rxs     <= rx_meta;
    end
  end

  // Divisor in use: live input while idle, frozen copy once a frame has started
  always_comb begin
    div_src = (state == ST_IDLE) ? baud_div : div_l;
    div_eff = (div_src == '0) ? DIV_W'(1) : div_src;
  end

  // >= rather than == so a smaller divisor never lets the counter run away
  assign tick = (tick_cnt >= (div_eff - DIV_W'(1)));

  // Free-running sample-tick generator
  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + DIV_W'(1);
  end

  assign maj       = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
  assign dec       = tick && (s_cnt == S_DEC);
  assign eob       = tick && (s_cnt == S_END);
  assign start_det = (state == ST_IDLE) && tick && !rxs;
  assign last_stop = (stop_idx == stop2_l);

  // Break needs the first stop decision low; when it is also the final one take it live
  assign first_stop_zero = (stop_idx == 1'b0) ? !maj : stop0_zero;
  assign brk_now  = (shreg == '0) && (!par_en_l || !par_bit) && first_stop_zero;
  assign fe_now   = fe_acc | !maj;
  assign rx_busy  = (state != ST_IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  end

  // FSM next state; frame_end marks the decision tick of the final stop bit
  always_comb begin
    state_nx  = state;
    frame_end = 1'b0;
    case (state)
      ST_IDLE:       if (tick && !rxs) state_nx = ST_START;
      ST_START: begin
        if (dec && maj) state_nx = ST_IDLE;
        else if (eob) state_nx = ST_DATA;
      end
      ST_DATA:       if (eob && (bit_idx == B_LAST)) state_nx = par_en_l ? ST_PARITY : ST_STOP;
      ST_PARITY:     if (eob) state_nx = ST_STOP;
      ST_STOP: begin
        if (dec && last_stop) begin
          frame_end = 1'b1;
          state_nx  = brk_now ? ST_BREAK_WAIT : ST_IDLE;
        end
      end
      ST_BREAK_WAIT: if (tick && rxs) state_nx = ST_IDLE;
      default:       state_nx = ST_IDLE;
    endcase
  end

  // Bit timing, sampling, shifting and per-frame configuration capture
  always_ff @(posedge clk) begin
    if (reset) begin
      s_cnt      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      samp0      <= 1'b1;
      samp1      <= 1'b1;
      shreg      <= '0;
      par_bit    <= 1'b0;
      par_err    <= 1'b0;
      fe_acc     <= 1'b0;
      stop0_zero <= 1'b0;
      div_l      <= '0;
      par_en_l   <= 1'b0;
      par_odd_l  <= 1'b0;
      stop2_l    <= 1'b0;
    end else if (start_det) begin
      s_cnt      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      par_bit    <= 1'b0;
      par_err    <= 1'b0;
      fe_acc     <= 1'b0;
      stop0_zero <= 1'b0;
      div_l      <= baud_div;
      par_en_l   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_odd_l  <= (parity_mode == 2'b10);
      stop2_l    <= stop2;
    end else if (tick && (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})) begin
      s_cnt <= (s_cnt == S_END) ? '0 : s_cnt + SW'(1);
      if (s_cnt == S_LO)  samp0 <= rxs;
      if (s_cnt == S_MID) samp1 <= rxs;
      if (dec) begin
        case (state)
          ST_DATA:   shreg <= {maj, shreg[DATA_BITS-1:1]};
          ST_PARITY: begin
            par_bit <= maj;
            par_err <= ((^shreg) ^ maj) != par_odd_l;
          end
          ST_STOP: begin
            if (!maj) fe_acc <= 1'b1;
            if (stop_idx == 1'b0) stop0_zero <= !maj;
          end
          default: ;
        endcase
      end
      if (eob) begin
        case (state)
          ST_DATA: bit_idx  <= bit_idx + BW'(1);
          ST_STOP: stop_idx <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Completion pulses and the valid/ready holding register with overrun drop
  always_ff @(posedge clk) begin
    if (reset) begin
      rx.rx_data       <= '0;
      rx.rx_valid      <= 1'b0;
      rx.rx_frame_err  <= 1'b0;
      rx.rx_parity_err <= 1'b0;
      rx_break         <= 1'b0;
      rx_overrun       <= 1'b0;
      rx_done          <= 1'b0;
    end else begin
      rx_done    <= frame_end;
      rx_break   <= frame_end && brk_now;
      rx_overrun <= 1'b0;
      if (frame_end) begin
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data       <= brk_now ? '0 : shreg;
          rx.rx_frame_err  <= fe_now;
          rx.rx_parity_err <= par_err;
          rx.rx_valid      <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param against a frame-level reference model
module tb_uart_rx_param;
  localparam int DB = 8;
  localparam int OS = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          RxD = 1'b1;
  logic [DW-1:0] baud_div = 16'd4;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop2 = 1'b0;
  logic          rx_break, rx_overrun, rx_done, rx_busy;

  uart_rx_param_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .DIV_W(DW)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .baud_div(baud_div),
    .parity_mode(parity_mode), .stop2(stop2), .rx(rx_if),
    .rx_break(rx_break), .rx_overrun(rx_overrun), .rx_done(rx_done), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int        done_cnt = 0, ovr_cnt = 0, brk_cnt = 0, vld_cyc = 0;
  logic [7:0] cap_data = 8'h00;
  logic      cap_fe = 1'b0, cap_pe = 1'b0, cap_vld = 1'b0, cap_brk = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_done) begin
        done_cnt++;
        cap_data = rx_if.rx_data;
        cap_fe   = rx_if.rx_frame_err;
        cap_pe   = rx_if.rx_parity_err;
        cap_vld  = rx_if.rx_valid;
        cap_brk  = rx_break;
      end
      if (rx_overrun) ovr_cnt++;
      if (rx_break) brk_cnt++;
      if (rx_if.rx_valid) vld_cyc++;
    end
  end

  int bp;

  function automatic int bit_period(input logic [DW-1:0] d);
    return ((d == 0) ? 1 : int'(d)) * OS;
  endfunction

  function automatic bit m_pen(input logic [1:0] pm);
    return (pm == 2'b01) || (pm == 2'b10);
  endfunction

  function automatic bit m_perr(input logic [7:0] d, input logic [1:0] pm, input bit pbit);
    case (pm)
      2'b01:   return ((^d) ^ pbit) != 1'b0;
      2'b10:   return ((^d) ^ pbit) != 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_brk(input logic [7:0] d, input bit pen, input bit pbit, input bit st0);
    return (d == 8'h00) && (!pen || !pbit) && !st0;
  endfunction

  task automatic drive(input logic b, input int n);
    RxD = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                            input bit two, input bit st0, input bit st1);
    drive(1'b0, bp);
    for (int i = 0; i < DB; i++) drive(d[i], bp);
    if (pen) drive(pbit, bp);
    drive(st0, bp);
    if (two) drive(st1, bp);
    drive(1'b1, 3 * bp);
  endtask

  task automatic frame_check(input string tag, input logic [7:0] d, input logic [1:0] pm,
                             input bit pbit, input bit two, input bit st0, input bit st1);
    int  d0;
    bit  pen, brk;
    pen = m_pen(pm);
    brk = m_brk(d, pen, pbit, st0);
    parity_mode = pm;
    stop2 = two;
    bp = bit_period(baud_div);
    d0 = done_cnt;
    send_frame(d, pen, pbit, two, st0, st1);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_data"}, cap_data, brk ? 8'h00 : d);
    check({tag, "_ferr"}, cap_fe, (!st0 || (two && !st1)) ? 1 : 0);
    check({tag, "_perr"}, cap_pe, m_perr(d, pm, pbit));
    check({tag, "_brk"}, cap_brk, brk);
  endtask

  int d0, o0, b0, v0;

  initial begin
    rx_if.rx_ready = 1'b1;
    bp = bit_period(baud_div);
    repeat (5) @(negedge clk);
    check("rst_busy", rx_busy, 0);
    check("rst_valid", rx_if.rx_valid, 0);
    check("rst_data", rx_if.rx_data, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ferr", rx_if.rx_frame_err, 0);
    check("rst_perr", rx_if.rx_parity_err, 0);
    check("rst_done", rx_done, 0);

    // 8N1 basic frame, valid held for exactly one cycle with ready high
    v0 = vld_cyc;
    frame_check("t1", 8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t1_vld", cap_vld, 1);
    check("t1_vldcyc", vld_cyc - v0, 1);

    // Even parity with wrong and right parity bit
    frame_check("t2a", 8'h3C, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
    frame_check("t2b", 8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);

    // Short low pulse is a false start
    parity_mode = 2'b00;
    d0 = done_cnt;
    drive(1'b0, 10);
    check("t3_busy_hi", rx_busy, 1);
    drive(1'b0, 10);
    drive(1'b1, 3 * bp);
    check("t3_nodone", done_cnt - d0, 0);
    check("t3_busy_lo", rx_busy, 0);

    // 1-clk spike inside data bit 0 is voted out
    d0 = done_cnt;
    drive(1'b0, bp);
    drive(1'b1, bp / 2);
    drive(1'b0, 1);
    drive(1'b1, bp / 2 - 1);
    for (int i = 1; i < DB; i++) drive(logic'((8'hA5 >> i) & 1), bp);
    drive(1'b1, bp);
    drive(1'b1, 3 * bp);
    check("t3_spk_done", done_cnt - d0, 1);
    check("t3_spk_data", cap_data, 8'hA5);
    check("t3_spk_ferr", cap_fe, 0);

    // Stop bit low gives a framing error
    frame_check("t4a", 8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Line held low for two frame times: one break, nothing more until it goes high
    d0 = done_cnt;
    b0 = brk_cnt;
    drive(1'b0, 20 * bp);
    check("t4_brk_busy", rx_busy, 1);
    drive(1'b1, 3 * bp);
    check("t4_brk_cnt", brk_cnt - b0, 1);
    check("t4_brk_done", done_cnt - d0, 1);
    check("t4_brk_data", cap_data, 0);
    check("t4_brk_ferr", cap_fe, 1);
    check("t4_brk_idle", rx_busy, 0);

    // Overrun: consumer stalled across two frames
    rx_if.rx_ready = 1'b0;
    o0 = ovr_cnt;
    frame_check("t5a", 8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    d0 = done_cnt;
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_done2", done_cnt - d0, 1);
    check("t5_ovr", ovr_cnt - o0, 1);
    check("t5_hold", rx_if.rx_data, 8'h11);
    check("t5_vld", rx_if.rx_valid, 1);
    rx_if.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_vld_drop", rx_if.rx_valid, 0);

    // Two stop bits, second one low
    frame_check("t6a", 8'hC3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset during the 4th data bit
    parity_mode = 2'b00;
    stop2 = 1'b0;
    d0 = done_cnt;
    drive(1'b0, bp);
    drive(1'b0, bp);
    drive(1'b1, bp);
    drive(1'b1, bp);
    drive(1'b1, bp / 2);
    check("t6_busy_pre", rx_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", rx_busy, 0);
    check("t6_rst_vld", rx_if.rx_valid, 0);
    check("t6_rst_data", rx_if.rx_data, 0);
    check("t6_rst_ferr", rx_if.rx_frame_err, 0);
    reset = 1'b0;
    drive(1'b1, 3 * bp);
    check("t6_rst_nodone", done_cnt - d0, 0);
    frame_check("t6b", 8'h7E, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Randomised frames across divisor, parity, stop count and injected errors
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      logic [1:0] pm;
      bit two, pbit, st0, st1;
      d = 8'($urandom);
      pm = 2'($urandom_range(0, 3));
      two = 1'($urandom_range(0, 1));
      pbit = (pm == 2'b10) ? ~(^d) : (^d);
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      st0 = ($urandom_range(0, 5) != 0);
      st1 = ($urandom_range(0, 5) != 0);
      baud_div = DW'($urandom_range(0, 5));
      frame_check($sformatf("rnd%0d", n), d, pm, pbit, two, st0, st1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds runtime baud divisor, configurable oversampling, data width, parity, 1/2 stop bits, a 2-flop input synchroniser, 3-sample majority vote, error flags, break detect and a valid/ready output holding register with overrun reporting. Sits between the RxD pin and the MCU peripheral bus register block.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line.
OVERSAMPLE, 16, sample ticks per bit, even, legal 8..32.
DIV_W, 16, width of baud_div.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
RxD  in  1  asynchronous serial line, idle high
baud_div  in  DIV_W  clk cycles per sample tick; 0 treated as 1
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
stop2  in  1  1 = two stop bits expected
rx_data  out  DATA_BITS  received data word
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
rx_frame_err  out  1  stop-bit error for the word in rx_data
rx_parity_err  out  1  parity error for the word in rx_data
rx_break  out  1  1-cycle pulse, break detected
rx_overrun  out  1  1-cycle pulse, completed frame dropped
rx_done  out  1  1-cycle pulse at every frame completion, dropped frames included
rx_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, active-high): all outputs 0, rx_data 0, synchroniser flops 1, tick counter 0, state IDLE. Reset mid-frame aborts the frame; no pulses emitted.
- Tick generator: counter 0..baud_div-1, tick asserted for one clk when counter == baud_div-1. Free-running in all states.
- Synchroniser: 2 flops on RxD; all logic uses the synchronised line rxs. Adds 2 clk latency.
- Sample counter s runs 0..OVERSAMPLE-1 per bit, advancing on ticks. Samples are taken at s = M-1, M, M+1 (M = OVERSAMPLE/2). Bit value is the majority of the 3 samples, decided at s = M+1.
- parity_mode, stop2 and baud_div are latched at start detection. Changes mid-frame have no effect until the next frame.
- FSM:
  - IDLE: on a tick with rxs==0, set s=0 and go to START.
  - START: at decision, majority 1 -> false start, return to IDLE with no pulses. Majority 0 -> continue; at s=OVERSAMPLE-1 go to DATA.
  - DATA: shift DATA_BITS bits LSB first. After the last bit, go to PARITY if parity is enabled, else STOP.
  - PARITY: even -> error if XOR(data, bit) != 0; odd -> error if XOR(data, bit) != 1.
  - STOP: 1 or 2 bits. Any stop decision 0 -> frame_err. The frame completes at the decision tick of the final stop bit; no wait for end of bit. Then go to IDLE, or to BREAK_WAIT if a break was detected.
  - BREAK_WAIT: stay until rxs==1 on a tick, then IDLE.
- Break: all data bits, parity (if enabled) and the first stop decision are 0. Result: rx_break pulse, frame_err=1, word delivered as 0.
- Completion (cycle after final decision tick): rx_done pulses.
  - If rx_valid==0, or rx_valid & rx_ready in the same cycle: load rx_data, rx_frame_err and rx_parity_err, and set rx_valid=1.
  - Else (rx_valid & !rx_ready): pulse rx_overrun, drop the new word, leave the holding register unchanged.
- Handshake: rx_valid stays high with data and flags stable until rx_valid & rx_ready; it clears the next cycle unless a new word loads in that same cycle.
- Latency: start edge on RxD to rx_valid is approximately 2 + baud_div*((1+DATA_BITS+P+S-1)*OVERSAMPLE + M+1) + 1 clk, where P is 1 if parity is enabled (else 0) and S is the stop-bit count.
- rx_data for DATA_BITS < 9 uses all bits; no padding.

Test Plan:
1. 8N1, baud_div=4, OVERSAMPLE=16, rx_ready=1, send 0xA5 -> one rx_done pulse, rx_valid 1 cycle, rx_data=0xA5, no error flags.
2. Even parity, send 0x3C with parity bit 1 -> rx_data=0x3C, rx_parity_err=1, rx_frame_err=0. The same frame with parity bit 0 -> no error.
3. RxD low pulse of 20 clk (shorter than M ticks = 32 clk) -> returns to IDLE, no rx_done, rx_busy drops. A 1-clk low spike inside a data bit -> majority vote rejects it and rx_data is correct.
4. Stop bit sent as 0 on 0x55 -> rx_frame_err=1. Line held low for 2 frame times -> rx_break pulse, rx_data=0x00, and no new start is accepted until the line has returned high.
5. rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, rx_overrun pulses once. Then raise rx_ready -> rx_valid drops.
6. stop2=1 with 2nd stop bit 0 -> frame_err. Assert reset at the 4th data bit -> all outputs 0, and the next clean frame 0x7E is received correctly.
